// File: rtl/myproject_sdiv_seq_24s_8s_16.sv
// Iterative signed divider (24s / 8s -> 16s quotient, 8s remainder).
// Inverse of the 16s x 8s multiply stage, used to undo a weight scaling.
// One restoring iteration per clock. Valid/ready handshakes on input and output.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst     synchronous active-high reset
//   in_valid   operands valid          in_ready  block can accept operands
//   dividend   signed dividend         divisor   signed divisor
//   out_valid  result valid            out_ready downstream accepts result
//   quotient   signed quotient, truncated toward zero, saturated
//   remainder  signed remainder, sign follows the dividend
//   ovf        quotient saturated      div0      divisor was zero
module myproject_sdiv_seq_24s_8s_16 #(
  parameter int unsigned DIVIDEND_W = 24,
  parameter int unsigned DIVISOR_W  = 8,
  parameter int unsigned QUOT_W     = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOT_W-1:0]     quotient,
  output logic signed [DIVISOR_W-1:0]  remainder,
  output logic                         ovf,
  output logic                         div0
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam logic signed [DIVIDEND_W:0] QMAX =
    $signed((DIVIDEND_W+1)'((1 << (QUOT_W-1)) - 1));
  localparam logic signed [DIVIDEND_W:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic                  sign_n, sign_d;
  // mag_n holds the dividend magnitude and, after CALC, the unsigned quotient
  logic [DIVIDEND_W-1:0] mag_n;
  logic [DIVISOR_W-1:0]  mag_d;
  logic [DIVISOR_W:0]    prem;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]          prem_sh;
  logic [DIVISOR_W+1:0]        trial;
  logic signed [DIVIDEND_W:0]  q_s;
  logic [DIVISOR_W-1:0]        rem_u;
  logic signed [QUOT_W-1:0]    fix_q;
  logic signed [DIVISOR_W-1:0] fix_r;
  logic                        fix_ovf, fix_div0;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_CALC;
      end
      S_CALC: begin
        if (cnt == '0) state_nx = S_FIXUP;
      end
      S_FIXUP: begin
        state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Restoring step: partial remainder never exceeds 2*127+1, so 9 bits suffice;
  // the extra top bit of trial is the borrow.
  always_comb begin
    prem_sh = {prem[DIVISOR_W-1:0], mag_n[DIVIDEND_W-1]};
    trial   = {1'b0, prem_sh} - {2'b00, mag_d};
  end

  // Sign restore and saturation of the final result
  always_comb begin
    q_s   = (sign_n ^ sign_d) ? -$signed({1'b0, mag_n}) : $signed({1'b0, mag_n});
    rem_u = prem[DIVISOR_W-1:0];
    fix_q    = q_s[QUOT_W-1:0];
    fix_r    = sign_n ? -rem_u : rem_u;
    fix_ovf  = 1'b0;
    fix_div0 = 1'b0;
    if (mag_d == '0) begin
      fix_div0 = 1'b1;
      fix_r    = '0;
      fix_q    = sign_n ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}};
    end else if (q_s > QMAX) begin
      fix_q   = {1'b0, {(QUOT_W-1){1'b1}}};
      fix_ovf = 1'b1;
    end else if (q_s < QMIN) begin
      fix_q   = {1'b1, {(QUOT_W-1){1'b0}}};
      fix_ovf = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sign_n    <= 1'b0;
      sign_d    <= 1'b0;
      mag_n     <= '0;
      mag_d     <= '0;
      prem      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_n <= dividend[DIVIDEND_W-1];
            sign_d <= divisor[DIVISOR_W-1];
            mag_n  <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
            mag_d  <= divisor[DIVISOR_W-1] ? -divisor : divisor;
            prem   <= '0;
            cnt    <= CNT_W'(DIVIDEND_W - 1);
          end
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (!trial[DIVISOR_W+1]) begin
            prem  <= trial[DIVISOR_W:0];
            mag_n <= {mag_n[DIVIDEND_W-2:0], 1'b1};
          end else begin
            prem  <= prem_sh;
            mag_n <= {mag_n[DIVIDEND_W-2:0], 1'b0};
          end
        end
        S_FIXUP: begin
          quotient  <= fix_q;
          remainder <= fix_r;
          ovf       <= fix_ovf;
          div0      <= fix_div0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_seq_24s_8s_16.sv
module tb_myproject_sdiv_seq_24s_8s_16;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] dividend;
  logic signed [7:0]  divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] quotient;
  logic signed [7:0]  remainder;
  logic               ovf;
  logic               div0;

  int n_checks = 0;
  int n_fail   = 0;

  myproject_sdiv_seq_24s_8s_16 #(
    .DIVIDEND_W(24),
    .DIVISOR_W (8),
    .QUOT_W    (16)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .ovf      (ovf),
    .div0     (div0)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands and return #1 after the accepting edge
  task automatic start_op(input string tag, input int dvd, input int dvs);
    int w;
    @(negedge ap_clk);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge ap_clk);
      w++;
    end
    check({tag, "_ready"}, int'(in_ready), 1);
    dividend = dvd[23:0];
    divisor  = dvs[7:0];
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen (61 = timeout)
  task automatic wait_valid(output int cyc);
    cyc = 61;
    for (int c = 1; c <= 60; c++) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input int dvd, input int dvs,
                       input int eq, input int er, input int eovf, input int ed0);
    int cyc;
    out_ready = 1'b1;
    start_op(tag, dvd, dvs);
    wait_valid(cyc);
    check({tag, "_lat"}, cyc, 25);
    check({tag, "_q"}, int'(quotient), eq);
    check({tag, "_r"}, int'(remainder), er);
    check({tag, "_ovf"}, int'(ovf), eovf);
    check({tag, "_div0"}, int'(div0), ed0);
    @(posedge ap_clk);
    #1;
    check({tag, "_vld_clr"}, int'(out_valid), 0);
    check({tag, "_rdy_set"}, int'(in_ready), 1);
  endtask

  initial begin
    int cyc;
    int r1, r2, nrise;
    logic prev;
    logic signed [15:0] q_hold;
    logic signed [7:0]  r_hold;

    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_flags", int'({ovf, div0}), 0);

    // Directed vectors, expected values worked by hand
    do_op("exact",    5000,     50,   100,    0, 0, 0);
    do_op("m7_2",     -7,       2,    -3,     -1, 0, 0);
    do_op("7_m2",     7,        -2,   -3,     1,  0, 0);
    do_op("m7_m2",    -7,       -2,   3,      -1, 0, 0);
    do_op("m100_7",   -100,     7,    -14,    -2, 0, 0);
    do_op("zero_n",   0,        5,    0,      0,  0, 0);
    do_op("minq",     -1048576, 32,   -32768, 0,  0, 0);
    do_op("sat_pos",  8388607,  1,    32767,  0,  1, 0);
    do_op("sat_neg",  -8388608, 1,    -32768, 0,  1, 0);
    do_op("sat_mm1",  -8388608, -1,   32767,  0,  1, 0);
    do_op("d_m128",   1000,     -128, -7,     104, 0, 0);
    do_op("div0_pos", 123,      0,    32767,  0,  0, 1);
    do_op("div0_neg", -5,       0,    -32768, 0,  0, 1);

    // Back-pressure: hold out_ready low for 10 cycles
    out_ready = 1'b0;
    start_op("hold", 1234, 10);
    wait_valid(cyc);
    check("hold_lat", cyc, 25);
    check("hold_q", int'(quotient), 123);
    check("hold_r", int'(remainder), 4);
    q_hold = quotient;
    r_hold = remainder;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      #1;
      if (!out_valid || in_ready || quotient !== q_hold || remainder !== r_hold) begin
        check("hold_stable", int'({out_valid, in_ready, quotient !== q_hold, remainder !== r_hold}), 8);
      end
    end
    check("hold_vld_end", int'(out_valid), 1);
    check("hold_rdy_end", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    check("hold_rel_vld", int'(out_valid), 0);
    check("hold_rel_rdy", int'(in_ready), 1);

    // Back-to-back operands with in_valid held high
    @(negedge ap_clk);
    dividend = 24'sd5000;
    divisor  = 8'sd50;
    in_valid = 1'b1;
    prev  = 1'b0;
    nrise = 0;
    r1 = 0;
    r2 = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge ap_clk);
      #1;
      if (out_valid && !prev) begin
        nrise++;
        if (nrise == 1) r1 = i;
        if (nrise == 2) r2 = i;
        check("b2b_q", int'(quotient), 100);
      end
      prev = out_valid;
    end
    check("b2b_rises", nrise, 2);
    check("b2b_period", r2 - r1, 27);
    @(negedge ap_clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge ap_clk);
      cyc++;
    end

    // Reset during CALC discards the operation and clears outputs
    out_ready = 1'b1;
    start_op("rst_mid", -7, 2);
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    check("rstm_in_ready", int'(in_ready), 1);
    check("rstm_out_valid", int'(out_valid), 0);
    check("rstm_q", int'(quotient), 0);
    check("rstm_r", int'(remainder), 0);
    check("rstm_flags", int'({ovf, div0}), 0);
    do_op("after_rst", 5000, 50, 100, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
